// File: rtl/hack_keyboard.sv
// PS/2 set-2 event decoder that maintains the Hack KBD register for the Nand2Tetris CPU.
// Two-stage pipeline: toggle-detect capture, then ROM lookup plus state update.
module hack_keyboard #(
  parameter bit CAPS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [15:0] kbd,
  output logic        kbd_stb,
  output logic        shift_o,
  output logic        caps_o
);

  logic       tog_q;
  logic       s1_valid;
  logic       s1_make;
  logic       s1_ext;
  logic [7:0] s1_scan;

  logic       shift_l;
  logic       shift_r;
  logic       caps_held;
  logic       held_valid;
  logic [8:0] held_key;
  logic [7:0] kbd_code;

  logic [15:0] pair;
  logic        is_letter;
  logic        shifted;
  logic [7:0]  code;
  logic        is_shift_key;
  logic        is_caps_key;

  // Returns {shifted_code, plain_code}; keys that ignore shift carry the same code twice.
  function automatic logic [15:0] set2_lookup(input logic ext, input logic [7:0] scan);
    logic [15:0] p;
    p = 16'h0000;
    if (ext) begin
      case (scan)
        8'h6B: p = {8'd130, 8'd130};
        8'h75: p = {8'd131, 8'd131};
        8'h74: p = {8'd132, 8'd132};
        8'h72: p = {8'd133, 8'd133};
        8'h6C: p = {8'd134, 8'd134};
        8'h69: p = {8'd135, 8'd135};
        8'h7D: p = {8'd136, 8'd136};
        8'h7A: p = {8'd137, 8'd137};
        8'h70: p = {8'd138, 8'd138};
        8'h71: p = {8'd139, 8'd139};
        default: p = 16'h0000;
      endcase
    end else begin
      case (scan)
        8'h1C: p = "Aa";  8'h32: p = "Bb";  8'h21: p = "Cc";  8'h23: p = "Dd";
        8'h24: p = "Ee";  8'h2B: p = "Ff";  8'h34: p = "Gg";  8'h33: p = "Hh";
        8'h43: p = "Ii";  8'h3B: p = "Jj";  8'h42: p = "Kk";  8'h4B: p = "Ll";
        8'h3A: p = "Mm";  8'h31: p = "Nn";  8'h44: p = "Oo";  8'h4D: p = "Pp";
        8'h15: p = "Qq";  8'h2D: p = "Rr";  8'h1B: p = "Ss";  8'h2C: p = "Tt";
        8'h3C: p = "Uu";  8'h2A: p = "Vv";  8'h1D: p = "Ww";  8'h22: p = "Xx";
        8'h35: p = "Yy";  8'h1A: p = "Zz";
        8'h16: p = "!1";  8'h1E: p = "@2";  8'h26: p = "#3";  8'h25: p = "$4";
        8'h2E: p = "%5";  8'h36: p = "^6";  8'h3D: p = "&7";  8'h3E: p = "*8";
        8'h46: p = "(9";  8'h45: p = ")0";
        8'h0E: p = {8'h7E, 8'h60};  8'h4E: p = "_-";  8'h55: p = "+=";  8'h54: p = "{[";
        8'h5B: p = "}]";  8'h5D: p = "|\\"; 8'h4C: p = ":;";  8'h52: p = "\"'";
        8'h41: p = "<,";  8'h49: p = ">.";  8'h4A: p = "?/";  8'h29: p = "  ";
        8'h5A: p = {8'd128, 8'd128};
        8'h66: p = {8'd129, 8'd129};
        8'h76: p = {8'd140, 8'd140};
        8'h05: p = {8'd141, 8'd141};
        8'h06: p = {8'd142, 8'd142};
        8'h04: p = {8'd143, 8'd143};
        8'h0C: p = {8'd144, 8'd144};
        8'h03: p = {8'd145, 8'd145};
        8'h0B: p = {8'd146, 8'd146};
        8'h83: p = {8'd147, 8'd147};
        8'h0A: p = {8'd148, 8'd148};
        8'h01: p = {8'd149, 8'd149};
        8'h09: p = {8'd150, 8'd150};
        8'h78: p = {8'd151, 8'd151};
        8'h07: p = {8'd152, 8'd152};
        default: p = 16'h0000;
      endcase
    end
    return p;
  endfunction

  // Caps-lock flips the shift sense only for letters, so digits and symbols keep their plain meaning.
  always_comb begin
    pair         = set2_lookup(s1_ext, s1_scan);
    is_letter    = (pair[7:0] >= 8'h61) && (pair[7:0] <= 8'h7A);
    shifted      = shift_o ^ (caps_o & is_letter);
    code         = shifted ? pair[15:8] : pair[7:0];
    is_shift_key = !s1_ext && ((s1_scan == 8'h12) || (s1_scan == 8'h59));
    is_caps_key  = CAPS_EN && !s1_ext && (s1_scan == 8'h58);
  end

  assign shift_o = shift_l | shift_r;
  assign kbd     = {8'h00, kbd_code};

  // Stage 0 captures the event on a toggle edge; stage 2 applies the looked-up stage-1 event.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q      <= ps2_key[10];
      s1_valid   <= 1'b0;
      s1_make    <= 1'b0;
      s1_ext     <= 1'b0;
      s1_scan    <= 8'h00;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      caps_o     <= 1'b0;
      caps_held  <= 1'b0;
      held_valid <= 1'b0;
      held_key   <= 9'h000;
      kbd_code   <= 8'h00;
      kbd_stb    <= 1'b0;
    end else begin
      tog_q    <= ps2_key[10];
      s1_valid <= (ps2_key[10] != tog_q);
      s1_make  <= ps2_key[9];
      s1_ext   <= ps2_key[8];
      s1_scan  <= ps2_key[7:0];
      kbd_stb  <= 1'b0;
      if (s1_valid) begin
        if (is_shift_key) begin
          if (s1_scan == 8'h12) shift_l <= s1_make;
          else                  shift_r <= s1_make;
        end else if (is_caps_key) begin
          // Typematic repeats of caps make arrive without a break; only the first one toggles.
          if (s1_make && !caps_held) caps_o <= ~caps_o;
          caps_held <= s1_make;
        end else if (s1_make) begin
          if (code != 8'h00) begin
            kbd_code   <= code;
            held_key   <= {s1_ext, s1_scan};
            held_valid <= 1'b1;
            kbd_stb    <= (code != kbd_code);
          end
        end else if (held_valid && (held_key == {s1_ext, s1_scan})) begin
          kbd_code   <= 8'h00;
          held_key   <= 9'h000;
          held_valid <= 1'b0;
          kbd_stb    <= (kbd_code != 8'h00);
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_keyboard.sv
// Directed self-checking bench for hack_keyboard: letters, shift, caps, specials, overlap, repeat, reset.
// Outputs are sampled on the falling edge; events are driven on the falling edge too.
module tb_hack_keyboard;

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] kbd;
  logic        kbd_stb;
  logic        shift_o;
  logic        caps_o;

  int errors = 0;
  int checks = 0;

  hack_keyboard #(.CAPS_EN(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .kbd     (kbd),
    .kbd_stb (kbd_stb),
    .shift_o (shift_o),
    .caps_o  (caps_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flip the toggle with a new event and return at the falling edge where its result is visible.
  task automatic send(input logic make, input logic ext, input logic [7:0] scan);
    @(negedge clk);
    ps2_key = {~ps2_key[10], make, ext, scan};
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ps2_key = 11'h000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (kbd !== 16'd0) begin errors++; $display("[TB] FAIL reset_kbd got=%0d want=0", kbd); end
    checks++;
    if ({kbd_stb, shift_o, caps_o} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got=%b want=000", {kbd_stb, shift_o, caps_o});
    end
  endtask

  task automatic test_letter();
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    @(negedge clk);
    checks++;
    if (kbd !== 16'd0) begin errors++; $display("[TB] FAIL a_latency got=%0d want=0", kbd); end
    @(negedge clk);
    checks++;
    if (kbd !== 16'd97 || kbd_stb !== 1'b1) begin
      errors++; $display("[TB] FAIL a_make got=%0d/%b want=97/1", kbd, kbd_stb);
    end
    @(negedge clk);
    checks++;
    if (kbd !== 16'd97 || kbd_stb !== 1'b0) begin
      errors++; $display("[TB] FAIL a_stb_once got=%0d/%b want=97/0", kbd, kbd_stb);
    end
    send(1'b0, 1'b0, 8'h1C);
    checks++;
    if (kbd !== 16'd0 || kbd_stb !== 1'b1) begin
      errors++; $display("[TB] FAIL a_break got=%0d/%b want=0/1", kbd, kbd_stb);
    end
  endtask

  task automatic test_shift();
    send(1'b1, 1'b0, 8'h12);
    checks++;
    if (shift_o !== 1'b1 || kbd !== 16'd0 || kbd_stb !== 1'b0) begin
      errors++; $display("[TB] FAIL shift_make got=%b/%0d/%b want=1/0/0", shift_o, kbd, kbd_stb);
    end
    send(1'b1, 1'b0, 8'h16);
    checks++;
    if (kbd !== 16'd33) begin errors++; $display("[TB] FAIL shift_bang got=%0d want=33", kbd); end
    send(1'b0, 1'b0, 8'h12);
    checks++;
    if (shift_o !== 1'b0 || kbd !== 16'd33) begin
      errors++; $display("[TB] FAIL shift_release got=%b/%0d want=0/33", shift_o, kbd);
    end
    send(1'b0, 1'b0, 8'h16);
    checks++;
    if (kbd !== 16'd0) begin errors++; $display("[TB] FAIL shift_break got=%0d want=0", kbd); end
  endtask

  task automatic test_caps();
    send(1'b1, 1'b0, 8'h58);
    checks++;
    if (caps_o !== 1'b1) begin errors++; $display("[TB] FAIL caps_on got=%b want=1", caps_o); end
    send(1'b0, 1'b0, 8'h58);
    send(1'b1, 1'b0, 8'h58);
    checks++;
    if (caps_o !== 1'b0) begin errors++; $display("[TB] FAIL caps_off got=%b want=0", caps_o); end
    send(1'b0, 1'b0, 8'h58);
    send(1'b1, 1'b0, 8'h58);
    send(1'b1, 1'b0, 8'h58);
    checks++;
    if (caps_o !== 1'b1) begin errors++; $display("[TB] FAIL caps_repeat got=%b want=1", caps_o); end
    send(1'b0, 1'b0, 8'h58);
    send(1'b1, 1'b0, 8'h1C);
    checks++;
    if (kbd !== 16'd65) begin errors++; $display("[TB] FAIL caps_A got=%0d want=65", kbd); end
    send(1'b0, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h59);
    send(1'b1, 1'b0, 8'h1C);
    checks++;
    if (kbd !== 16'd97) begin errors++; $display("[TB] FAIL caps_shift_a got=%0d want=97", kbd); end
    send(1'b0, 1'b0, 8'h1C);
    send(1'b0, 1'b0, 8'h59);
    send(1'b1, 1'b0, 8'h16);
    checks++;
    if (kbd !== 16'd49) begin errors++; $display("[TB] FAIL caps_digit got=%0d want=49", kbd); end
    send(1'b0, 1'b0, 8'h16);
    send(1'b1, 1'b0, 8'h58);
    send(1'b0, 1'b0, 8'h58);
    checks++;
    if (caps_o !== 1'b0 || kbd !== 16'd0) begin
      errors++; $display("[TB] FAIL caps_restore got=%b/%0d want=0/0", caps_o, kbd);
    end
  endtask

  task automatic test_overlap();
    send(1'b1, 1'b1, 8'h75);
    checks++;
    if (kbd !== 16'd131) begin errors++; $display("[TB] FAIL up_make got=%0d want=131", kbd); end
    send(1'b1, 1'b0, 8'h5A);
    checks++;
    if (kbd !== 16'd128) begin errors++; $display("[TB] FAIL enter_over got=%0d want=128", kbd); end
    send(1'b0, 1'b1, 8'h75);
    checks++;
    if (kbd !== 16'd128 || kbd_stb !== 1'b0) begin
      errors++; $display("[TB] FAIL stale_break got=%0d/%b want=128/0", kbd, kbd_stb);
    end
    send(1'b0, 1'b0, 8'h5A);
    checks++;
    if (kbd !== 16'd0) begin errors++; $display("[TB] FAIL enter_break got=%0d want=0", kbd); end
    send(1'b1, 1'b0, 8'h07);
    checks++;
    if (kbd !== 16'd152) begin errors++; $display("[TB] FAIL f12_make got=%0d want=152", kbd); end
    send(1'b0, 1'b0, 8'h07);
  endtask

  task automatic test_repeat();
    send(1'b1, 1'b0, 8'h66);
    checks++;
    if (kbd !== 16'd129 || kbd_stb !== 1'b1) begin
      errors++; $display("[TB] FAIL bksp_first got=%0d/%b want=129/1", kbd, kbd_stb);
    end
    for (int i = 0; i < 2; i++) begin
      send(1'b1, 1'b0, 8'h66);
      checks++;
      if (kbd !== 16'd129 || kbd_stb !== 1'b0) begin
        errors++; $display("[TB] FAIL bksp_repeat%0d got=%0d/%b want=129/0", i, kbd, kbd_stb);
      end
    end
    send(1'b1, 1'b0, 8'h14);
    checks++;
    if (kbd !== 16'd129 || kbd_stb !== 1'b0) begin
      errors++; $display("[TB] FAIL ctrl_ignored got=%0d/%b want=129/0", kbd, kbd_stb);
    end
    send(1'b0, 1'b0, 8'h66);
    send(1'b0, 1'b0, 8'h14);
    checks++;
    if (kbd !== 16'd0) begin errors++; $display("[TB] FAIL repeat_clear got=%0d want=0", kbd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h12};
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (kbd !== 16'd65 || shift_o !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_make got=%0d/%b want=65/1", kbd, shift_o);
    end
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h1C};
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h12};
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (kbd !== 16'd0 || shift_o !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_break got=%0d/%b want=0/0", kbd, shift_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (kbd !== 16'd0 || kbd_stb !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_now got=%0d/%b want=0/0", kbd, kbd_stb);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (kbd !== 16'd0 || kbd_stb !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_after%0d got=%0d/%b want=0/0", i, kbd, kbd_stb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_letter();
    test_shift();
    test_caps();
    test_overlap();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
